neuron_param_loader: RTL and testbench



---
 rtl/neuron_param_loader.sv | 137 +++++++++++++
 tb/tb_neuron_param_loader.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_param_loader.sv
// Framed byte-stream loader for the LIF neuron's weights, decay shift and
// threshold. Bytes land in shadow registers; the active outputs are only
// rewritten in a single cycle once a whole frame has arrived, so the neuron
// never observes a mix of old and new parameters.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_SYNC    | waiting for the sync byte; other bytes flag frame_error
// ST_WEIGHTS | collecting weight bytes, least-significant byte first
// ST_SHIFT   | next byte carries the decay shift in bits 2:0
// ST_THRESH  | next byte carries the threshold (saturated if too wide)
// ST_COMMIT  | one cycle, in_ready low; shadow copied to active outputs
module neuron_param_loader #(
  parameter int          SYNAPSES       = 32,
  parameter int          THRESHOLD_BITS = $clog2(SYNAPSES) + 1,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      frame_abort,
  input  logic                      clear_error,
  output logic [SYNAPSES-1:0]       weights,
  output logic [2:0]                shift,
  output logic [THRESHOLD_BITS-1:0] threshold,
  output logic                      param_loaded,
  output logic                      frame_error
);

  localparam int W_BYTES = SYNAPSES / 8;
  localparam int CNT_W   = (W_BYTES > 1) ? $clog2(W_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(W_BYTES - 1);

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_WEIGHTS,
    ST_SHIFT,
    ST_THRESH,
    ST_COMMIT
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [CNT_W-1:0]          cnt;
  logic [SYNAPSES-1:0]       shadow_w;
  logic [2:0]                shadow_s;
  logic [THRESHOLD_BITS-1:0] shadow_t;
  logic [THRESHOLD_BITS-1:0] thr_conv;
  logic                      accept;
  logic                      abort_now;

  // in_ready is held low while in reset as well as during the commit cycle.
  assign in_ready  = rst_n && (state != ST_COMMIT);
  assign abort_now = frame_abort && (state != ST_COMMIT);
  assign accept    = in_valid && in_ready && !frame_abort;

  // Map the threshold byte onto the threshold width: zero-extend or saturate.
  always_comb begin
    thr_conv = THRESHOLD_BITS'(in_data);
    if (THRESHOLD_BITS < 8) begin
      if (int'(in_data) >= (1 << THRESHOLD_BITS)) thr_conv = '1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_SYNC;
    else        state <= state_nxt;
  end

  // Next-state logic; abort returns to SYNC from any state but COMMIT.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_SYNC: begin
        if (accept && (in_data == SYNC_BYTE)) state_nxt = ST_WEIGHTS;
      end
      ST_WEIGHTS: begin
        if (abort_now)                         state_nxt = ST_SYNC;
        else if (accept && (cnt == LAST_IDX))  state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (abort_now)   state_nxt = ST_SYNC;
        else if (accept) state_nxt = ST_THRESH;
      end
      ST_THRESH: begin
        if (abort_now)   state_nxt = ST_SYNC;
        else if (accept) state_nxt = ST_COMMIT;
      end
      ST_COMMIT: state_nxt = ST_SYNC;
      default:   state_nxt = ST_SYNC;
    endcase
  end

  // Shadow capture, atomic commit, load pulse and sticky sync error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      shadow_w     <= '0;
      shadow_s     <= '0;
      shadow_t     <= '0;
      weights      <= '0;
      shift        <= '0;
      threshold    <= '1;
      param_loaded <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      param_loaded <= (state == ST_COMMIT);
      if (state == ST_COMMIT) begin
        weights   <= shadow_w;
        shift     <= shadow_s;
        threshold <= shadow_t;
      end

      if (abort_now) begin
        cnt <= '0;
      end else if (accept) begin
        case (state)
          ST_SYNC: cnt <= '0;
          ST_WEIGHTS: begin
            shadow_w[{cnt, 3'b000} +: 8] <= in_data;
            cnt <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
          end
          ST_SHIFT:  shadow_s <= in_data[2:0];
          ST_THRESH: shadow_t <= thr_conv;
          default: ;
        endcase
      end

      if (accept && (state == ST_SYNC) && (in_data != SYNC_BYTE)) frame_error <= 1'b1;
      else if (clear_error)                                         frame_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_neuron_param_loader.sv
// Bench for neuron_param_loader with SYNAPSES=32 (4 weight bytes, 6-bit
// threshold). Expected parameter sets come from the frame bytes themselves.
module tb_neuron_param_loader;

  localparam int WB    = 4;
  localparam int TBITS = 6;

  typedef logic [7:0] frame_t [7];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        frame_abort = 1'b0;
  logic        clear_error = 1'b0;
  logic [31:0] weights;
  logic [2:0]  shift;
  logic [5:0]  threshold;
  logic        param_loaded;
  logic        frame_error;

  int vectors = 0;
  int errors  = 0;
  bit rand_gaps = 0;

  int          pulse_cnt = 0;
  bit          out_glitch = 0;
  logic [31:0] prev_w = '0;
  logic [2:0]  prev_s = '0;
  logic [5:0]  prev_t = '1;
  logic [31:0] cap_w[$];
  logic [2:0]  cap_s[$];
  logic [5:0]  cap_t[$];

  neuron_param_loader dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .frame_abort(frame_abort), .clear_error(clear_error),
    .weights(weights), .shift(shift), .threshold(threshold),
    .param_loaded(param_loaded), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  // Record every committed parameter set and flag any output change without a pulse.
  always @(negedge clk) begin
    if (rst_n && !param_loaded && (weights !== prev_w || shift !== prev_s || threshold !== prev_t))
      out_glitch = 1;
    if (rst_n && param_loaded) begin
      pulse_cnt++;
      cap_w.push_back(weights);
      cap_s.push_back(shift);
      cap_t.push_back(threshold);
    end
    prev_w = weights;
    prev_s = shift;
    prev_t = threshold;
  end

  function automatic logic [31:0] mdl_w(input frame_t f);
    logic [31:0] w = 0;
    for (int k = 0; k < WB; k++) w = w + (32'(f[1+k]) << (8 * k));
    return w;
  endfunction

  function automatic logic [2:0] mdl_s(input frame_t f);
    return 3'(f[5] % 8);
  endfunction

  function automatic logic [5:0] mdl_t(input frame_t f);
    int lim = (1 << TBITS);
    return (int'(f[6]) >= lim) ? 6'(lim - 1) : 6'(f[6]);
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    f[0] = 8'hA5;
    for (int i = 1; i < 7; i++) f[i] = 8'($urandom_range(255));
    return f;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n;
    if (rand_gaps) begin
      n = 0;
      while ($urandom_range(1) == 1 && n < 6) begin
        @(negedge clk);
        in_valid = 1'b0;
        n++;
      end
    end
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      vectors++;
      errors++;
      $display("FAIL handshake: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_frame(input frame_t f);
    for (int i = 0; i < 7; i++) send_byte(f[i]);
  endtask

  task automatic clear_caps();
    cap_w.delete();
    cap_s.delete();
    cap_t.delete();
  endtask

  task automatic test_reset();
    #12;
    vectors++; if (weights !== 32'h0) begin errors++; $display("FAIL reset_weights: got %h, required %h", weights, 32'h0); end
    vectors++; if (shift !== 3'd0) begin errors++; $display("FAIL reset_shift: got %0d, required 0", shift); end
    vectors++; if (threshold !== 6'h3f) begin errors++; $display("FAIL reset_threshold: got %0d, required 63", threshold); end
    vectors++; if (param_loaded !== 1'b0) begin errors++; $display("FAIL reset_param_loaded: got %b, required 0", param_loaded); end
    vectors++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_frame_error: got %b, required 0", frame_error); end
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %b, required 1", in_ready); end
  endtask

  task automatic test_basic();
    frame_t f = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h05, 8'h10};
    int base = pulse_cnt;
    send_frame(f);
    @(negedge clk);
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL commit_in_ready: got %b, required 0", in_ready); end
    vectors++; if (param_loaded !== 1'b0) begin errors++; $display("FAIL early_pulse: got %b, required 0", param_loaded); end
    vectors++; if (weights !== 32'h0) begin errors++; $display("FAIL early_weights: got %h, required %h", weights, 32'h0); end
    @(negedge clk);
    vectors++; if (param_loaded !== 1'b1) begin errors++; $display("FAIL pulse_latency: got %b, required 1", param_loaded); end
    vectors++; if (weights !== 32'h44332211) begin errors++; $display("FAIL basic_weights: got %h, required %h", weights, 32'h44332211); end
    vectors++; if (shift !== 3'd5) begin errors++; $display("FAIL basic_shift: got %0d, required 5", shift); end
    vectors++; if (threshold !== 6'd16) begin errors++; $display("FAIL basic_threshold: got %0d, required 16", threshold); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_commit_ready: got %b, required 1", in_ready); end
    vectors++; if (frame_error !== 1'b0) begin errors++; $display("FAIL basic_frame_error: got %b, required 0", frame_error); end
    @(negedge clk);
    vectors++; if (param_loaded !== 1'b0) begin errors++; $display("FAIL pulse_width: got %b, required 0", param_loaded); end
    vectors++; if (pulse_cnt !== base + 1) begin errors++; $display("FAIL basic_pulse_count: got %0d, required %0d", pulse_cnt - base, 1); end
  endtask

  task automatic test_saturate();
    frame_t f;
    clear_caps();
    f = rand_frame();
    f[5] = 8'hFB;
    f[6] = 8'h50;
    send_frame(f);
    repeat (3) @(negedge clk);
    vectors++;
    if (cap_w.size() != 1) begin
      errors++; $display("FAIL sat_commits: got %0d, required 1", cap_w.size());
    end else begin
      if (cap_w[0] !== mdl_w(f) || cap_s[0] !== 3'd3 || cap_t[0] !== 6'd63) begin
        errors++;
        $display("FAIL sat_values: got w=%h s=%0d t=%0d, required w=%h s=3 t=63", cap_w[0], cap_s[0], cap_t[0], mdl_w(f));
      end
    end
  endtask

  task automatic test_random_frames();
    frame_t f;
    for (int i = 0; i < 6; i++) begin
      clear_caps();
      f = rand_frame();
      if (i == 0) f[6] = 8'h3F;
      if (i == 1) f[6] = 8'h40;
      send_frame(f);
      repeat (3) @(negedge clk);
      vectors++;
      if (cap_w.size() != 1) begin
        errors++; $display("FAIL rand_commits[%0d]: got %0d, required 1", i, cap_w.size());
      end else if (cap_w[0] !== mdl_w(f) || cap_s[0] !== mdl_s(f) || cap_t[0] !== mdl_t(f)) begin
        errors++;
        $display("FAIL rand_values[%0d]: got w=%h s=%0d t=%0d, required w=%h s=%0d t=%0d",
                 i, cap_w[0], cap_s[0], cap_t[0], mdl_w(f), mdl_s(f), mdl_t(f));
      end
    end
  endtask

  task automatic test_sync_error();
    frame_t f = rand_frame();
    clear_caps();
    send_byte(8'h3C);
    @(negedge clk);
    vectors++; if (frame_error !== 1'b1) begin errors++; $display("FAIL sync_err_set: got %b, required 1", frame_error); end
    send_frame(f);
    repeat (3) @(negedge clk);
    vectors++;
    if (cap_w.size() != 1 || cap_w[0] !== mdl_w(f) || cap_t[0] !== mdl_t(f)) begin
      errors++; $display("FAIL sync_err_commit: got %0d commits w=%h, required 1 w=%h", cap_w.size(), weights, mdl_w(f));
    end
    vectors++; if (frame_error !== 1'b1) begin errors++; $display("FAIL sync_err_sticky: got %b, required 1", frame_error); end
    clear_error = 1'b1;
    @(negedge clk);
    clear_error = 1'b0;
    vectors++; if (frame_error !== 1'b0) begin errors++; $display("FAIL clear_error: got %b, required 0", frame_error); end
    in_data = 8'h3C;
    in_valid = 1'b1;
    clear_error = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    clear_error = 1'b0;
    vectors++; if (frame_error !== 1'b1) begin errors++; $display("FAIL mismatch_wins: got %b, required 1", frame_error); end
    clear_error = 1'b1;
    @(negedge clk);
    clear_error = 1'b0;
    vectors++; if (frame_error !== 1'b0) begin errors++; $display("FAIL clear_error2: got %b, required 0", frame_error); end
  endtask

  task automatic test_abort();
    frame_t f = '{8'hA5, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h05, 8'h10};
    int base = pulse_cnt;
    send_byte(8'hA5);
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk);
    frame_abort = 1'b1;
    in_data = 8'h33;
    in_valid = 1'b1;
    @(negedge clk);
    frame_abort = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (pulse_cnt !== base) begin errors++; $display("FAIL abort_no_pulse: got %0d pulses, required 0", pulse_cnt - base); end
    for (int i = 0; i < 7; i++) send_byte(f[i]);
    @(negedge clk);
    frame_abort = 1'b1;
    @(negedge clk);
    frame_abort = 1'b0;
    vectors++; if (param_loaded !== 1'b1) begin errors++; $display("FAIL abort_in_commit: got %b, required 1", param_loaded); end
    vectors++; if (weights !== 32'hDDCCBBAA) begin errors++; $display("FAIL abort_weights: got %h, required %h", weights, 32'hDDCCBBAA); end
    vectors++; if (shift !== 3'd5 || threshold !== 6'd16) begin errors++; $display("FAIL abort_shift_thr: got %0d/%0d, required 5/16", shift, threshold); end
    @(negedge clk);
    vectors++; if (pulse_cnt !== base + 1) begin errors++; $display("FAIL abort_pulse_count: got %0d, required 1", pulse_cnt - base); end
  endtask

  task automatic test_back_to_back();
    frame_t f1 = rand_frame();
    frame_t f2 = rand_frame();
    int base = pulse_cnt;
    clear_caps();
    rand_gaps = 1;
    send_frame(f1);
    send_frame(f2);
    rand_gaps = 0;
    repeat (3) @(negedge clk);
    vectors++; if (pulse_cnt !== base + 2) begin errors++; $display("FAIL b2b_pulses: got %0d, required 2", pulse_cnt - base); end
    vectors++;
    if (cap_w.size() != 2) begin
      errors++; $display("FAIL b2b_commits: got %0d, required 2", cap_w.size());
    end else if (cap_w[0] !== mdl_w(f1) || cap_s[0] !== mdl_s(f1) || cap_t[0] !== mdl_t(f1) ||
                 cap_w[1] !== mdl_w(f2) || cap_s[1] !== mdl_s(f2) || cap_t[1] !== mdl_t(f2)) begin
      errors++;
      $display("FAIL b2b_values: got %h/%h, required %h/%h", cap_w[0], cap_w[1], mdl_w(f1), mdl_w(f2));
    end
    vectors++; if (out_glitch !== 1'b0) begin errors++; $display("FAIL no_intermediate: got change-without-pulse=%b, required 0", out_glitch); end
  endtask

  task automatic test_reset_mid();
    frame_t f1 = rand_frame();
    frame_t f2 = rand_frame();
    send_frame(f1);
    repeat (3) @(negedge clk);
    send_byte(8'hA5);
    send_byte(8'h11);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++; if (weights !== 32'h0) begin errors++; $display("FAIL rst_mid_weights: got %h, required 0", weights); end
    vectors++; if (shift !== 3'd0) begin errors++; $display("FAIL rst_mid_shift: got %0d, required 0", shift); end
    vectors++; if (threshold !== 6'd63) begin errors++; $display("FAIL rst_mid_threshold: got %0d, required 63", threshold); end
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_in_ready: got %b, required 0", in_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_caps();
    send_frame(f2);
    repeat (3) @(negedge clk);
    vectors++;
    if (cap_w.size() != 1 || cap_w[0] !== mdl_w(f2) || cap_s[0] !== mdl_s(f2) || cap_t[0] !== mdl_t(f2)) begin
      errors++;
      $display("FAIL rst_mid_reload: got %0d commits w=%h s=%0d t=%0d, required 1 w=%h s=%0d t=%0d",
               cap_w.size(), weights, shift, threshold, mdl_w(f2), mdl_s(f2), mdl_t(f2));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_random_frames();
    test_sync_error();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
